nand_seq_ctrl: RTL and testbench
================================

# nand_seq_ctrl

Sequencer for the NAND pad interface of the core. It accepts single-beat read/write requests from core logic over a req/ack handshake. It drives the chip-select, address and write-data pad signals, which feed the pad mux toward the P_NAND_* pads, through a fixed setup/access/hold sequence with a programmable access length. On reads it captures the returned pad data. It sits inside the core, in front of the nand_cs_o / nand_addr_o / nand_wdata_o / nand_rdata_i outputs and inputs.

## Interface
Parameters:
- ADDR_W, 2, NAND address width
- DATA_W, 2, NAND data width
- WAIT_W, 4, width of the access-length field

Ports:
- xtal_i  input  1  clock; all state on rising edge
- reset_i  input  1  asynchronous, active-low reset
- req_i  input  1  transaction request; held until ack_o
- we_i  input  1  1 = write, 0 = read
- addr_i  input  ADDR_W  transaction address
- wdata_i  input  DATA_W  write data
- wait_i  input  WAIT_W  extra access cycles; ACCESS lasts wait_i+1 cycles
- ack_o  output  1  one-cycle completion pulse
- rdata_o  output  DATA_W  last captured read data
- busy_o  output  1  high in every state except IDLE
- nand_cs_o  output  1  chip select, active-low
- nand_addr_o  output  ADDR_W  pad address
- nand_wdata_o  output  DATA_W  pad write data
- nand_rdata_i  input  DATA_W  pad read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - If req_i=1, latch we_i, addr_i, wdata_i and wait_i into internal registers, then go to SETUP.
  - Inputs are sampled only in IDLE.
- SETUP: lasts 1 cycle.
  - nand_cs_o=0; nand_addr_o = latched address.
  - nand_wdata_o = latched data on writes, else 0.
  - Counter loads the latched wait value.
- ACCESS: pad outputs as in SETUP; counter decrements each cycle.
  - When counter==0, go to HOLD.
  - On a read, rdata_o captures nand_rdata_i on that same edge.
- HOLD: lasts 1 cycle.
  - nand_cs_o=0; address and write data held.
  - ack_o=1 for this cycle only; next state IDLE.
- IDLE pad values: nand_cs_o=1, nand_addr_o=0, nand_wdata_o=0.
- There is always at least one IDLE cycle (cs deasserted) between transactions.
- Handshake rule:
  - The requester drops req_i the cycle after it sees ack_o.
  - If req_i is still high in that IDLE cycle, a new transaction starts with the current inputs. This is the intended back-to-back mode.
- Writes never modify rdata_o; rdata_o holds until the next read capture.
- Input changes while busy_o=1 are ignored.
- Reset asserted mid-transaction: FSM goes to IDLE immediately, pads return to idle values, no ack_o.

## Timing
- Reset values:
  - ack_o=0, rdata_o=0, busy_o=0
  - nand_cs_o=1, nand_addr_o=0, nand_wdata_o=0
  - state IDLE, counter 0
- Let edge E0 be the edge where IDLE samples req_i=1.
  - SETUP occupies cycle 1.
  - ACCESS occupies cycles 2..2+W, where W = latched wait_i.
  - HOLD occupies cycle 3+W.
- ack_o is high in cycle 3+W. Request-to-ack latency = W+3 cycles.
- nand_cs_o is low for W+3 cycles.
- Back-to-back throughput: one transaction per W+4 cycles.
- wait_i=0 gives ACCESS = 1 cycle. wait_i = 2^WAIT_W−1 gives ACCESS = 2^WAIT_W cycles; the counter must not wrap.
- Read capture edge: the end of the last ACCESS cycle. rdata_o is valid in the ack_o cycle.

## Configuration
- NAND_SEQ_RDATA_SYNC_EN, defined:
  - nand_rdata_i passes through a 2-flop synchronizer (reset 0) before capture.
  - The ACCESS counter loads wait+2, so ACCESS = W+3 cycles, ack at cycle W+5, cs low for W+5 cycles.
- Undefined:
  - nand_rdata_i is captured directly; timing as above.

## Test plan
- Reset check: hold reset_i=0 -> all outputs at reset values. Release, wait 5 cycles with req_i=0 -> nand_cs_o stays 1, busy_o=0.
- Write, W=0:
  - Stimulus: req_i=1, we_i=1, addr_i=2'b10, wdata_i=2'b01, wait_i=0.
  - Response: cs low cycles 1–3, addr=2'b10 and wdata=2'b01 throughout, ack_o in cycle 3 only, rdata_o unchanged.
- Read, W=5:
  - Stimulus: addr_i=2'b11, nand_rdata_i=2'b10.
  - Response: ack_o in cycle 8, rdata_o=2'b10 from cycle 8, cs low 8 cycles.
- Back-to-back: req_i held high across ack_o, W=1 -> exactly one IDLE cycle with cs=1 between transactions, second ack 5 cycles after the first.
- Reset mid-operation: reset_i pulled low during ACCESS of a W=15 read -> cs=1 immediately, no ack_o, rdata_o=0. After release, a new request completes normally.
- Macro check: with NAND_SEQ_RDATA_SYNC_EN defined, a W=2 read of 2'b01 -> ack_o at cycle 7, rdata_o=2'b01.

Source files
------------

// File: rtl/nand_seq_ctrl.sv
// nand_seq_ctrl: single-beat NAND pad sequencer.
// A request accepted in IDLE runs SETUP (1 cycle), ACCESS (wait+1 cycles)
// and HOLD (1 cycle, ack_o pulse), then returns to IDLE for at least one
// cycle with chip select deasserted. Pad outputs are registered.
// Optional macro NAND_SEQ_RDATA_SYNC_EN: read data passes through a 2-flop
// synchronizer before capture, and ACCESS is stretched by two cycles so the
// synchronizer has caught up by the capture edge.
module nand_seq_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2,
    parameter int WAIT_W = 4
) (
    input  logic              xtal_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [WAIT_W-1:0] wait_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              nand_cs_o,
    output logic [ADDR_W-1:0] nand_addr_o,
    output logic [DATA_W-1:0] nand_wdata_o,
    input  logic [DATA_W-1:0] nand_rdata_i
);

    // One extra bit so wait+2 at the top of the wait range cannot wrap.
    localparam int CNT_W = WAIT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t              state;
    logic                lat_we;
    logic [WAIT_W-1:0]   lat_wait;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   cap_data;

`ifdef NAND_SEQ_RDATA_SYNC_EN
    localparam logic [CNT_W-1:0] CNT_EXTRA = CNT_W'(2);

    logic [DATA_W-1:0] sync_q1;
    logic [DATA_W-1:0] sync_q2;

    // Two-flop synchronizer on the returning pad data.
    always_ff @(posedge xtal_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= nand_rdata_i;
            sync_q2 <= sync_q1;
        end
    end

    assign cap_data = sync_q2;
`else
    localparam logic [CNT_W-1:0] CNT_EXTRA = '0;

    assign cap_data = nand_rdata_i;
`endif

    // Sequencer FSM with registered pad, handshake and status outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would create order-dependent races.
    always_ff @(posedge xtal_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= S_IDLE;
            lat_we       <= 1'b0;
            lat_wait     <= '0;
            cnt          <= '0;
            ack_o        <= 1'b0;
            rdata_o      <= '0;
            busy_o       <= 1'b0;
            nand_cs_o    <= 1'b1;
            nand_addr_o  <= '0;
            nand_wdata_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o <= 1'b0;
                    if (req_i) begin
                        lat_we       <= we_i;
                        lat_wait     <= wait_i;
                        nand_cs_o    <= 1'b0;
                        nand_addr_o  <= addr_i;
                        nand_wdata_o <= we_i ? wdata_i : '0;
                        busy_o       <= 1'b1;
                        state        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt   <= {1'b0, lat_wait} + CNT_EXTRA;
                    state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        ack_o <= 1'b1;
                        state <= S_HOLD;
                        if (!lat_we) begin
                            rdata_o <= cap_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    ack_o        <= 1'b0;
                    nand_cs_o    <= 1'b1;
                    nand_addr_o  <= '0;
                    nand_wdata_o <= '0;
                    busy_o       <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// tb_nand_seq_ctrl: self-checking bench for nand_seq_ctrl.
// A transaction-level reference model predicts every output each cycle from
// the request length (wait+3, or wait+5 with NAND_SEQ_RDATA_SYNC_EN) and a
// per-edge history of the pad read data.
module tb_nand_seq_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 2;
    localparam int WAIT_W = 4;

`ifdef NAND_SEQ_RDATA_SYNC_EN
    localparam int LAT_EXTRA = 2;
    localparam int SYNC_DLY  = 2;
`else
    localparam int LAT_EXTRA = 0;
    localparam int SYNC_DLY  = 0;
`endif

    logic              xtal_i;
    logic              reset_i;
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [WAIT_W-1:0] wait_i;
    logic              ack_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic              nand_cs_o;
    logic [ADDR_W-1:0] nand_addr_o;
    logic [DATA_W-1:0] nand_wdata_o;
    logic [DATA_W-1:0] nand_rdata_i;

    nand_seq_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .WAIT_W(WAIT_W)
    ) dut (
        .xtal_i      (xtal_i),
        .reset_i     (reset_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wait_i      (wait_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .nand_cs_o   (nand_cs_o),
        .nand_addr_o (nand_addr_o),
        .nand_wdata_o(nand_wdata_o),
        .nand_rdata_i(nand_rdata_i)
    );

    initial begin
        xtal_i = 1'b0;
        forever #5 xtal_i = ~xtal_i;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transaction is just "busy for len cycles, ack in
    // the last one, read data taken from the pad sample at the edge that
    // enters the last cycle (delayed by the synchronizer depth)".
    bit                m_busy;
    int                m_k;
    int                m_len;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    int                ecount;
    logic [DATA_W-1:0] hist [int];

    task automatic model_reset();
        m_busy  = 1'b0;
        m_k     = 0;
        m_len   = 0;
        m_rdata = '0;
        hist[ecount]     = '0;
        hist[ecount - 1] = '0;
    endtask

    task automatic model_edge();
        ecount++;
        hist[ecount] = reset_i ? nand_rdata_i : '0;
        if (!reset_i) begin
            m_busy  = 1'b0;
            m_rdata = '0;
        end else if (!m_busy) begin
            if (req_i) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_len   = int'(wait_i) + 3 + LAT_EXTRA;
                m_we    = we_i;
                m_addr  = addr_i;
                m_wdata = wdata_i;
            end
        end else if (m_k == m_len) begin
            m_busy = 1'b0;
        end else begin
            m_k++;
            if (m_k == m_len && !m_we) begin
                m_rdata = hist[ecount - SYNC_DLY];
            end
        end
    endtask

    task automatic compare_all();
        check("cs",    32'(nand_cs_o),    32'(!m_busy));
        check("busy",  32'(busy_o),       32'(m_busy));
        check("addr",  32'(nand_addr_o),  m_busy ? 32'(m_addr) : 32'd0);
        check("wdata", 32'(nand_wdata_o), (m_busy && m_we) ? 32'(m_wdata) : 32'd0);
        check("ack",   32'(ack_o),        32'(m_busy && (m_k == m_len)));
        check("rdata", 32'(rdata_o),      32'(m_rdata));
    endtask

    // One clock: inputs already stable, model advances on the edge, outputs
    // are compared 1 time unit later.
    task automatic step();
        @(posedge xtal_i);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_req(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [WAIT_W-1:0] w);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        wdata_i = d;
        wait_i  = w;
    endtask

    // Issue one request, count cycles until ack (bounded), drop req after.
    task automatic run_txn(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [WAIT_W-1:0] w);
        int lat;
        int cs_low;
        set_req(we, a, d, w);
        lat    = 0;
        cs_low = 0;
        do begin
            step();
            lat++;
            if (!nand_cs_o) cs_low++;
        end while (!ack_o && lat < 60);
        req_i = 1'b0;
        check({tag, "_lat"},    32'(lat),    32'(int'(w) + 3 + LAT_EXTRA));
        check({tag, "_cs_low"}, 32'(cs_low), 32'(int'(w) + 3 + LAT_EXTRA));
        step();
    endtask

    initial begin
        int n;
        int gap;
        int cs_hi;

        reset_i      = 1'b1;
        req_i        = 1'b0;
        we_i         = 1'b0;
        addr_i       = '0;
        wdata_i      = '0;
        wait_i       = '0;
        nand_rdata_i = '0;
        ecount       = 0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        model_reset();

        // Reset state, then idle cycles with no request.
        #1 reset_i = 1'b0;
        #1;
        compare_all();
        repeat (2) step();
        #2 reset_i = 1'b1;
        repeat (5) step();

        // Write, W=0.
        run_txn("wr_w0", 1'b1, 2'b10, 2'b01, 4'd0);

        // Read, W=5, pad returns 2'b10.
        nand_rdata_i = 2'b10;
        run_txn("rd_w5", 1'b0, 2'b11, 2'b00, 4'd5);
        check("rd_w5_data", 32'(rdata_o), 32'(2'b10));

        // Write must not disturb rdata_o.
        nand_rdata_i = 2'b01;
        run_txn("wr_keep", 1'b1, 2'b01, 2'b11, 4'd2);
        check("wr_keep_rdata", 32'(rdata_o), 32'(2'b10));

        // Longest access: counter must not wrap.
        nand_rdata_i = 2'b11;
        run_txn("rd_w15", 1'b0, 2'b00, 2'b00, 4'd15);
        check("rd_w15_data", 32'(rdata_o), 32'(2'b11));

        // Back-to-back: req held high across ack.
        set_req(1'b1, 2'b01, 2'b10, 4'd1);
        n = 0;
        do begin step(); n++; end while (!ack_o && n < 40);
        check("b2b_first_ack", 32'(ack_o), 32'd1);
        gap   = 0;
        cs_hi = 0;
        do begin
            step();
            gap++;
            if (nand_cs_o) cs_hi++;
        end while (!ack_o && gap < 40);
        req_i = 1'b0;
        check("b2b_period", 32'(gap), 32'(1 + 4 + LAT_EXTRA));
        check("b2b_idle_cycles", 32'(cs_hi), 32'd1);
        repeat (2) step();

        // Reset mid-ACCESS of a W=15 read.
        nand_rdata_i = 2'b01;
        set_req(1'b0, 2'b10, 2'b00, 4'd15);
        repeat (6) step();
        req_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_mid_cs", 32'(nand_cs_o), 32'd1);
        repeat (2) step();
        #2 reset_i = 1'b1;
        n = 0;
        repeat (20) begin
            step();
            if (ack_o) n++;
        end
        check("rst_mid_no_ack", 32'(n), 32'd0);
        nand_rdata_i = 2'b01;
        run_txn("post_rst", 1'b0, 2'b01, 2'b00, 4'd2);
        check("post_rst_data", 32'(rdata_o), 32'(2'b01));

        // Randomized traffic with pad data changing every cycle.
        for (int i = 0; i < 1500; i++) begin
            req_i        = ($urandom_range(0, 9) < 6);
            we_i         = 1'($urandom_range(0, 1));
            addr_i       = ADDR_W'($urandom_range(0, 3));
            wdata_i      = DATA_W'($urandom_range(0, 3));
            wait_i       = ($urandom_range(0, 7) == 0) ? 4'd15 : WAIT_W'($urandom_range(0, 3));
            nand_rdata_i = DATA_W'($urandom_range(0, 3));
            step();
        end
        req_i = 1'b0;
        repeat (25) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
